br_predict_bht: RTL and testbench
=================================

Name: br_predict_bht

Overview:
Dynamic branch predictor that replaces always-not-taken resolution with a direct-mapped branch history table (BHT) and branch target buffer (BTB).
- IF stage: looks up i_pc_IF and supplies a predicted direction and target.
- EX stage: resolves the actual outcome from the comparator flags, detects mispredictions, supplies the corrected PC and flush, and trains the table.
- Also keeps branch and mispredict performance counters.

Parameters:
- BHT_DEPTH, 64, number of table entries; power of 2, minimum 4.
- IDX_W, $clog2(BHT_DEPTH), index width (derived).
- TAG_W, 30-IDX_W, tag width (derived).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_pc_IF  in  32  fetch PC to look up.
- o_pred_taken_IF  out  1  predicted taken for i_pc_IF.
- o_pred_target_IF  out  32  predicted target; valid when o_pred_taken_IF=1, otherwise i_pc_IF+4.
- i_valid_EX  in  1  EX holds a real instruction (0 = bubble).
- i_instr_EX  in  32  instruction in EX.
- i_pc_EX  in  32  PC of instruction in EX.
- i_pred_taken_EX  in  1  prediction carried down the pipe with this instruction.
- i_pred_target_EX  in  32  predicted target carried down the pipe.
- i_target_EX  in  32  actual target computed by the ALU (branch/JAL/JALR).
- i_brc_less  in  1  comparator less flag.
- i_brc_equal  in  1  comparator equal flag.
- o_ctrl  out  1  EX holds a valid branch or jump.
- o_mispred  out  1  misprediction detected in EX.
- o_flush  out  1  flush IF/ID; equals o_mispred.
- o_pc_correct  out  32  PC to redirect to when o_mispred=1.
- o_br_count  out  32  count of resolved control instructions.
- o_mispred_count  out  32  count of mispredictions.

Behaviour:
- Address fields: index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry contents: valid, tag, target[31:0], is_jump, ctr[1:0].
- Decode in EX, from instr[6:2]:
  - Branch = 11000; Jump = 11011 (JAL) or 11001 (JALR).
  - o_ctrl = i_valid_EX & (Branch | Jump).
- Actual outcome in EX:
  - Jump: always taken.
  - Branch, by funct3: BEQ = equal; BNE = ~equal; BLT/BLTU = less; BGE/BGEU = ~less; funct3 010/011 = not taken.
- IF lookup is combinational (asynchronous table read):
  - hit = valid & tag match.
  - o_pred_taken_IF = hit & (is_jump | ctr[1]).
  - o_pred_target_IF = stored target if predicted taken, else i_pc_IF+4.
- Misprediction (combinational), asserted only when o_ctrl=1:
  - o_mispred = (taken != i_pred_taken_EX) | (taken & i_pred_taken_EX & i_target_EX != i_pred_target_EX).
  - o_pc_correct = taken ? i_target_EX : i_pc_EX+4.
  - When o_ctrl=0: o_mispred=0 and o_pc_correct=i_pc_EX+4.
- Training, at the clock edge when o_ctrl=1:
  - Hit, branch: ctr saturating +1 if taken (max 3), -1 if not taken (min 0). Target rewritten if taken.
  - Hit, jump: target rewritten with i_target_EX.
  - Miss, taken: allocate (overwrite) entry. valid=1, tag, target=i_target_EX, is_jump=Jump, ctr=2'b10.
  - Miss, not taken: no write.
- Same-index collision: an IF lookup and EX update in the same cycle give IF the pre-update contents. No bypass.
- Performance counters:
  - o_br_count increments when o_ctrl=1.
  - o_mispred_count increments when o_mispred=1.
  - Both are 32-bit and wrap to 0 after 0xFFFFFFFF.
- Reset (synchronous):
  - All valid bits clear to 0, all ctr to 2'b01, both counters to 0.
  - Training is suppressed in the reset cycle.
  - While i_rst=1, o_pred_taken_IF=0 and o_mispred=o_flush=0.
  - Reset asserted mid-training discards that cycle's update.
  - First lookup after reset always misses.
- Latency: prediction 0 cycles; mispredict/flush 0 cycles after EX; training visible to IF lookups from the next cycle.

Test Plan:
- Reset, then BEQ at PC 0x100 with equal=1 and pred 0 -> o_mispred=1, o_pc_correct=target 0x140. Next cycle, lookup of 0x100 gives pred_taken=1, target=0x140, ctr=10.
- Same BEQ resolved taken 3 times, then not-taken once -> ctr goes 10→11→11 (saturated), then 10. Prediction stays taken; the not-taken resolution flags a mispredict with o_pc_correct=0x104.
- BNE not-taken at miss PC 0x200 with pred 0 -> no mispredict, no allocation; o_br_count +1, o_mispred_count unchanged.
- JALR at 0x300 predicted taken to 0x400, actual 0x480 -> o_mispred=1, o_pc_correct=0x480; entry target updates to 0x480.
- PCs 0x100 and 0x100+4*BHT_DEPTH alias to the same index -> the second allocation evicts the first; lookup of 0x100 then misses on tag. Same-cycle lookup and update returns the old entry.
- i_valid_EX=0 with a branch opcode -> o_ctrl=0, no training, counters unchanged. Force o_br_count to 0xFFFFFFFF and resolve one branch -> counter wraps to 0.

Source files
------------

// File: rtl/br_predict_bht.sv
// rtl/br_predict_bht.sv - direct-mapped BHT/BTB branch predictor with EX-stage resolution and training
module br_predict_bht #(
  parameter  int BHT_DEPTH = 64,
  localparam int IDX_W     = $clog2(BHT_DEPTH),
  localparam int TAG_W     = 30 - IDX_W
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_IF,
  output logic        o_pred_taken_IF,
  output logic [31:0] o_pred_target_IF,
  input  logic        i_valid_EX,
  input  logic [31:0] i_instr_EX,
  input  logic [31:0] i_pc_EX,
  input  logic        i_pred_taken_EX,
  input  logic [31:0] i_pred_target_EX,
  input  logic [31:0] i_target_EX,
  input  logic        i_brc_less,
  input  logic        i_brc_equal,
  output logic        o_ctrl,
  output logic        o_mispred,
  output logic        o_flush,
  output logic [31:0] o_pc_correct,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  // Table storage, one element per entry
  logic             valid_q  [BHT_DEPTH];
  logic [TAG_W-1:0] tag_q    [BHT_DEPTH];
  logic [31:0]      target_q [BHT_DEPTH];
  logic             jump_q   [BHT_DEPTH];
  logic [1:0]       ctr_q    [BHT_DEPTH];

  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  // Address fields for both lookup ports
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;

  assign if_idx = i_pc_IF[IDX_W+1:2];
  assign if_tag = i_pc_IF[31:IDX_W+2];
  assign ex_idx = i_pc_EX[IDX_W+1:2];
  assign ex_tag = i_pc_EX[31:IDX_W+2];

  // Only opcode and funct3 fields matter for control decode
  logic unused_instr_bits;
  assign unused_instr_bits = ^{i_instr_EX[31:15], i_instr_EX[11:7], i_instr_EX[1:0]};

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic       is_branch, is_jump;

  assign opcode    = i_instr_EX[6:2];
  assign funct3    = i_instr_EX[14:12];
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign o_ctrl    = i_valid_EX & (is_branch | is_jump);

  // IF lookup: asynchronous read, so a same-cycle EX write is not seen here
  logic if_hit, if_taken;

  assign if_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign if_taken = if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]) && !i_rst;

  assign o_pred_taken_IF  = if_taken;
  assign o_pred_target_IF = if_taken ? target_q[if_idx] : (i_pc_IF + 32'd4);

  // Actual direction of the instruction in EX
  logic taken;

  always_comb begin
    taken = 1'b0;
    if (is_jump) begin
      taken = 1'b1;
    end else if (is_branch) begin
      case (funct3)
        3'b000:  taken = i_brc_equal;
        3'b001:  taken = ~i_brc_equal;
        3'b100:  taken = i_brc_less;
        3'b101:  taken = ~i_brc_less;
        3'b110:  taken = i_brc_less;
        3'b111:  taken = ~i_brc_less;
        default: taken = 1'b0;
      endcase
    end
  end

  // Misprediction and redirect; a wrong target on a correctly predicted taken also redirects
  logic mispred_raw;

  assign mispred_raw = o_ctrl &
                       ((taken != i_pred_taken_EX) |
                        (taken & i_pred_taken_EX & (i_target_EX != i_pred_target_EX)));

  assign o_mispred    = mispred_raw & ~i_rst;
  assign o_flush      = o_mispred;
  assign o_pc_correct = (o_ctrl && taken) ? i_target_EX : (i_pc_EX + 32'd4);

  // Training decision for the entry addressed by the EX PC
  logic       ex_hit;
  logic       wr_alloc, wr_ctr, wr_target;
  logic [1:0] ctr_next;

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  always_comb begin
    wr_alloc  = 1'b0;
    wr_ctr    = 1'b0;
    wr_target = 1'b0;
    ctr_next  = ctr_q[ex_idx];
    if (o_ctrl) begin
      if (ex_hit) begin
        if (is_jump) begin
          wr_target = 1'b1;
        end else begin
          wr_ctr    = 1'b1;
          wr_target = taken;
          if (taken) begin
            ctr_next = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : (ctr_q[ex_idx] + 2'd1);
          end else begin
            ctr_next = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : (ctr_q[ex_idx] - 2'd1);
          end
        end
      end else if (taken) begin
        wr_alloc = 1'b1;
      end
    end
  end

  // Table update; reset clears every entry and drops the concurrent training write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (wr_alloc) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= i_target_EX;
      jump_q[ex_idx]   <= is_jump;
      ctr_q[ex_idx]    <= 2'b10;
    end else begin
      if (wr_ctr) begin
        ctr_q[ex_idx] <= ctr_next;
      end
      if (wr_target) begin
        target_q[ex_idx] <= i_target_EX;
      end
    end
  end

  // Performance counter next-state; both wrap naturally at 32 bits
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (o_ctrl) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (o_mispred) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign o_br_count      = br_count_q;
  assign o_mispred_count = mispred_count_q;

endmodule

// File: tb/tb_br_predict_bht.sv
// tb/tb_br_predict_bht.sv - scoreboard bench for br_predict_bht
module tb_br_predict_bht;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_pc_IF;
  logic        o_pred_taken_IF;
  logic [31:0] o_pred_target_IF;
  logic        i_valid_EX;
  logic [31:0] i_instr_EX;
  logic [31:0] i_pc_EX;
  logic        i_pred_taken_EX;
  logic [31:0] i_pred_target_EX;
  logic [31:0] i_target_EX;
  logic        i_brc_less;
  logic        i_brc_equal;
  logic        o_ctrl;
  logic        o_mispred;
  logic        o_flush;
  logic [31:0] o_pc_correct;
  logic [31:0] o_br_count;
  logic [31:0] o_mispred_count;

  br_predict_bht #(.BHT_DEPTH(64)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_pc_IF          (i_pc_IF),
    .o_pred_taken_IF  (o_pred_taken_IF),
    .o_pred_target_IF (o_pred_target_IF),
    .i_valid_EX       (i_valid_EX),
    .i_instr_EX       (i_instr_EX),
    .i_pc_EX          (i_pc_EX),
    .i_pred_taken_EX  (i_pred_taken_EX),
    .i_pred_target_EX (i_pred_target_EX),
    .i_target_EX      (i_target_EX),
    .i_brc_less       (i_brc_less),
    .i_brc_equal      (i_brc_equal),
    .o_ctrl           (o_ctrl),
    .o_mispred        (o_mispred),
    .o_flush          (o_flush),
    .o_pc_correct     (o_pc_correct),
    .o_br_count       (o_br_count),
    .o_mispred_count  (o_mispred_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic        pt;
    logic [31:0] ptgt;
    logic        ctrl;
    logic        mis;
    logic [31:0] pcc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          step_no  = 0;
  logic [31:0] br_exp   = 32'd0;
  logic [31:0] mis_exp  = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [31:0] br_op(input logic [2:0] f3);
    br_op = {17'd0, f3, 5'd0, 7'b1100011};
  endfunction

  localparam logic [31:0] JALR_OP = 32'h0000_0067;
  localparam logic [31:0] JAL_OP  = 32'h0000_006F;
  localparam logic [31:0] NOP_OP  = 32'h0000_0013;

  // One cycle: drive inputs, queue the expected outputs, compare, clock, check counters
  task automatic step(input logic rst, input logic [31:0] pc_if,
                      input logic valid, input logic [31:0] instr, input logic [31:0] pc_ex,
                      input logic pred_t, input logic [31:0] pred_tgt, input logic [31:0] tgt,
                      input logic less, input logic eq,
                      input logic e_pt, input logic [31:0] e_ptgt,
                      input logic e_ctrl, input logic e_mis, input logic [31:0] e_pcc);
    exp_t e;
    @(negedge i_clk);
    step_no++;
    i_rst            = rst;
    i_pc_IF          = pc_if;
    i_valid_EX       = valid;
    i_instr_EX       = instr;
    i_pc_EX          = pc_ex;
    i_pred_taken_EX  = pred_t;
    i_pred_target_EX = pred_tgt;
    i_target_EX      = tgt;
    i_brc_less       = less;
    i_brc_equal      = eq;
    e.rst = rst; e.pt = e_pt; e.ptgt = e_ptgt; e.ctrl = e_ctrl; e.mis = e_mis; e.pcc = e_pcc;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check_eq($sformatf("s%0d pred_taken", step_no), {31'd0, o_pred_taken_IF}, {31'd0, e.pt});
    check_eq($sformatf("s%0d pred_target", step_no), o_pred_target_IF, e.ptgt);
    check_eq($sformatf("s%0d ctrl", step_no), {31'd0, o_ctrl}, {31'd0, e.ctrl});
    check_eq($sformatf("s%0d mispred", step_no), {31'd0, o_mispred}, {31'd0, e.mis});
    check_eq($sformatf("s%0d flush", step_no), {31'd0, o_flush}, {31'd0, e.mis});
    check_eq($sformatf("s%0d pc_correct", step_no), o_pc_correct, e.pcc);
    @(posedge i_clk);
    if (e.rst) begin
      br_exp  = 32'd0;
      mis_exp = 32'd0;
    end else begin
      br_exp  = br_exp + {31'd0, e.ctrl};
      mis_exp = mis_exp + {31'd0, e.mis};
    end
    #1;
    check_eq($sformatf("s%0d br_count", step_no), o_br_count, br_exp);
    check_eq($sformatf("s%0d mispred_count", step_no), o_mispred_count, mis_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset: bubble, then a taken BEQ whose training and flush must be suppressed
    step(1, 32'h100, 0, NOP_OP,    32'h0,   0, 32'h0, 32'h0,   0, 0,  0, 32'h104, 0, 0, 32'h4);
    step(1, 32'h100, 1, br_op(0),  32'h100, 0, 32'h0, 32'h140, 0, 1,  0, 32'h104, 1, 0, 32'h140);
    // First lookup after reset misses
    step(0, 32'h100, 0, NOP_OP,    32'h0,   0, 32'h0, 32'h0,   0, 0,  0, 32'h104, 0, 0, 32'h4);
    // BEQ taken, predicted not-taken: mispredict and allocate; same-cycle lookup sees old entry
    step(0, 32'h100, 1, br_op(0),  32'h100, 0, 32'h0,   32'h140, 0, 1,  0, 32'h104, 1, 1, 32'h140);
    // Three more taken resolutions drive ctr 10 -> 11 -> 11 -> 11
    step(0, 32'h100, 1, br_op(0),  32'h100, 1, 32'h140, 32'h140, 0, 1,  1, 32'h140, 1, 0, 32'h140);
    step(0, 32'h100, 1, br_op(0),  32'h100, 1, 32'h140, 32'h140, 0, 1,  1, 32'h140, 1, 0, 32'h140);
    step(0, 32'h100, 1, br_op(0),  32'h100, 1, 32'h140, 32'h140, 0, 1,  1, 32'h140, 1, 0, 32'h140);
    // Not-taken: mispredict to fallthrough, ctr 11 -> 10
    step(0, 32'h100, 1, br_op(0),  32'h100, 1, 32'h140, 32'h140, 0, 0,  1, 32'h140, 1, 1, 32'h104);
    // Still predicted taken at 10; another not-taken brings ctr to 01
    step(0, 32'h100, 1, br_op(0),  32'h100, 1, 32'h140, 32'h140, 0, 0,  1, 32'h140, 1, 1, 32'h104);
    // Now predicted not-taken; BNE at 0x200 not taken on a miss: no allocation
    step(0, 32'h100, 1, br_op(1),  32'h200, 0, 32'h0,   32'h240, 0, 1,  0, 32'h104, 1, 0, 32'h204);
    // 0x200 still misses; JALR at 0x300 allocates with target 0x400
    step(0, 32'h200, 1, JALR_OP,   32'h300, 0, 32'h0,   32'h400, 0, 0,  0, 32'h204, 1, 1, 32'h400);
    // JALR predicted 0x400, actual 0x480: target mismatch mispredict, target rewritten
    step(0, 32'h300, 1, JALR_OP,   32'h300, 1, 32'h400, 32'h480, 0, 0,  1, 32'h400, 1, 1, 32'h480);
    // Bubble carrying a branch opcode: no control, no training, counters hold
    step(0, 32'h300, 0, br_op(0),  32'h500, 0, 32'h0,   32'h540, 0, 1,  1, 32'h480, 0, 0, 32'h504);
    // 0x100 evicted by 0x300 (same index); reallocate 0x100
    step(0, 32'h100, 1, br_op(0),  32'h100, 0, 32'h0,   32'h140, 0, 1,  0, 32'h104, 1, 1, 32'h140);
    // BLT at alias 0x200 allocates and evicts 0x100; same-cycle lookup returns old 0x100 entry
    step(0, 32'h100, 1, br_op(4),  32'h200, 0, 32'h0,   32'h280, 1, 0,  1, 32'h140, 1, 1, 32'h280);
    // 0x100 now misses on tag; BGE taken at 0x200 correctly predicted, ctr 10 -> 11
    step(0, 32'h100, 1, br_op(5),  32'h200, 1, 32'h280, 32'h280, 0, 0,  0, 32'h104, 1, 0, 32'h280);
    // BGEU not taken at a missing aliased PC: no write
    step(0, 32'h200, 1, br_op(7),  32'h600, 0, 32'h0,   32'h680, 1, 0,  1, 32'h280, 1, 0, 32'h604);
    // funct3 010 is never taken: mispredict, ctr 11 -> 10
    step(0, 32'h200, 1, br_op(2),  32'h200, 1, 32'h280, 32'h280, 1, 1,  1, 32'h280, 1, 1, 32'h204);
    // BLTU not taken: ctr 10 -> 01
    step(0, 32'h200, 1, br_op(6),  32'h200, 1, 32'h280, 32'h280, 0, 0,  1, 32'h280, 1, 1, 32'h204);
    // Entry now predicts not-taken; JAL at a fresh index allocates
    step(0, 32'h200, 1, JAL_OP,    32'h804, 0, 32'h0,   32'h900, 0, 0,  0, 32'h204, 1, 1, 32'h900);
    // Jump entry predicts taken regardless of counter
    step(0, 32'h804, 0, NOP_OP,    32'h0,   0, 32'h0,   32'h0,   0, 0,  1, 32'h900, 0, 0, 32'h4);

    // Branch counter wrap
    force dut.br_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    #1;
    check_eq("br_count forced", o_br_count, 32'hFFFF_FFFF);
    br_exp = 32'hFFFF_FFFF;
    step(0, 32'h804, 1, br_op(0),  32'h700, 0, 32'h0,   32'h740, 0, 0,  1, 32'h900, 1, 0, 32'h704);

    // Reset during a training cycle: update discarded, outputs masked, table cleared
    step(1, 32'h804, 1, br_op(0),  32'h808, 0, 32'h0,   32'h840, 0, 1,  0, 32'h808, 1, 0, 32'h840);
    step(0, 32'h808, 0, NOP_OP,    32'h0,   0, 32'h0,   32'h0,   0, 0,  0, 32'h80C, 0, 0, 32'h4);
    step(0, 32'h804, 0, NOP_OP,    32'h0,   0, 32'h0,   32'h0,   0, 0,  0, 32'h808, 0, 0, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
